// File: rtl/display_pkg.sv
// Shared definitions for the SSD1306-style display link: command codes, framebuffer
// geometry and the command-decoder state encoding.
package display_pkg;

    localparam int unsigned COLS     = 128;
    localparam int unsigned PAGES    = 8;
    localparam int unsigned FB_BYTES = 1024;

    localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
    localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON   = 8'hAF;

    typedef enum logic [2:0] {
        StIdle,
        StColStart,
        StColEnd,
        StPgStart,
        StPgEnd
    } cmd_state_e;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI byte receiver: synchronizes the link inputs into the clk domain, detects sclk rises
// and reassembles MSB-first bytes together with the dc flag seen on the last bit.
module spi_byte_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_sclk,
    input  logic       io_sdin,
    input  logic       io_cs,
    input  logic       io_dc,
    input  logic       io_reset,
    output logic       soft_rst,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc
);

    // The display-reset synchronizer is cleared only by rst so it can release soft_rst.
    logic [SYNC_STAGES-1:0] rsync_q, rsync_d;
    logic [3:0]             sync_q [SYNC_STAGES];
    logic [3:0]             sync_d [SYNC_STAGES];
    logic [3:0]             sync_s;  // {dc, cs, sdin, sclk}

    logic       sclk_prev_q, sclk_prev_d;
    logic       cs_prev_q, cs_prev_d;
    logic       rise_q, rise_d;
    logic       sdin_q, sdin_d;
    logic       dc_q, dc_d;
    logic       cs_hi_q, cs_hi_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       byte_dc_q, byte_dc_d;

    assign soft_rst   = rst | ~rsync_q[SYNC_STAGES-1];
    assign sync_s     = sync_q[SYNC_STAGES-1];
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign byte_dc    = byte_dc_q;

    always_comb begin
        rsync_d   = {rsync_q[SYNC_STAGES-2:0], io_reset};
        sync_d[0] = {io_dc, io_cs, io_sdin, io_sclk};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        sclk_prev_d = sync_s[0];
        cs_prev_d   = sync_s[2];
        // Qualify with the previous cs so a cs rise coinciding with the 8th edge still counts.
        rise_d      = sync_s[0] & ~sclk_prev_q & ~cs_prev_q;
        sdin_d      = sync_s[1];
        dc_d        = sync_s[3];
        cs_hi_d     = sync_s[2];

        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        byte_dc_d    = byte_dc_q;
        if (rise_q) begin
            shreg_d = {shreg_q[6:0], sdin_q};
            if (bitcnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                byte_data_d  = {shreg_q[6:0], sdin_q};
                byte_dc_d    = dc_q;
                bitcnt_d     = 3'd0;
            end else begin
                bitcnt_d = bitcnt_q + 3'd1;
            end
        end else if (cs_hi_q) begin
            bitcnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsync_q <= '1;
        end else begin
            rsync_q <= rsync_d;
        end
    end

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 4'b0100;
            end
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b1;
            rise_q       <= 1'b0;
            sdin_q       <= 1'b0;
            dc_q         <= 1'b0;
            cs_hi_q      <= 1'b1;
            shreg_q      <= 8'h00;
            bitcnt_q     <= 3'd0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_dc_q    <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            sclk_prev_q  <= sclk_prev_d;
            cs_prev_q    <= cs_prev_d;
            rise_q       <= rise_d;
            sdin_q       <= sdin_d;
            dc_q         <= dc_d;
            cs_hi_q      <= cs_hi_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            byte_dc_q    <= byte_dc_d;
        end
    end

endmodule

// File: rtl/receptor_display.sv
// Display-side receiver: decodes the command subset and turns data bytes into framebuffer
// writes using horizontal addressing inside the current column/page window.
module receptor_display #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COLS        = 128,
    parameter int unsigned PAGES       = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  io_sclk,
    input  logic                                  io_sdin,
    input  logic                                  io_cs,
    input  logic                                  io_dc,
    input  logic                                  io_reset,
    output logic                                  wr_en,
    output logic [$clog2(COLS)+$clog2(PAGES)-1:0] wr_addr,
    output logic [7:0]                            wr_data,
    output logic                                  cmd_valid,
    output logic [7:0]                            cmd_byte,
    output logic                                  display_on,
    output logic                                  frame_done,
    output logic [$clog2(COLS*PAGES)-1:0]         byte_count
);

    import display_pkg::*;

    localparam int unsigned ColW  = $clog2(COLS);
    localparam int unsigned PageW = $clog2(PAGES);
    localparam int unsigned CntW  = $clog2(COLS * PAGES);

    logic       soft_rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_dc;

    spi_byte_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .io_sclk   (io_sclk),
        .io_sdin   (io_sdin),
        .io_cs     (io_cs),
        .io_dc     (io_dc),
        .io_reset  (io_reset),
        .soft_rst  (soft_rst),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_dc   (byte_dc)
    );

    cmd_state_e             state_q, state_d;
    logic [ColW-1:0]        col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
    logic [PageW-1:0]       page_start_q, page_start_d, page_end_q, page_end_d, page_q, page_d;
    logic                   display_on_q, display_on_d;
    logic                   wr_en_q, wr_en_d;
    logic [ColW+PageW-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [7:0]             cmd_byte_q, cmd_byte_d;
    logic                   frame_done_q, frame_done_d;
    logic [CntW-1:0]        byte_count_q, byte_count_d;
    logic                   frame_pend_q, frame_pend_d;

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;
    assign display_on = display_on_q;
    assign frame_done = frame_done_q;
    assign byte_count = byte_count_q;

    always_comb begin
        state_d      = state_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        col_d        = col_q;
        page_d       = page_q;
        display_on_d = display_on_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        frame_done_d = 1'b0;
        byte_count_d = byte_count_q;
        frame_pend_d = frame_pend_q;

        if (byte_valid && byte_dc) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = {page_q, col_q};
            wr_data_d    = byte_data;
            byte_count_d = frame_pend_q ? CntW'(1) : byte_count_q + 1'b1;
            frame_done_d = (col_q == col_end_q) && (page_q == page_end_q);
            frame_pend_d = frame_done_d;
            // Fixed-width increments wrap naturally when start > end.
            if (col_q != col_end_q) begin
                col_d = col_q + 1'b1;
            end else begin
                col_d  = col_start_q;
                page_d = (page_q == page_end_q) ? page_start_q : page_q + 1'b1;
            end
        end else if (byte_valid) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = byte_data;
            unique case (state_q)
                StIdle: begin
                    if (byte_data == CMD_COL_ADDR) begin
                        state_d = StColStart;
                    end else if (byte_data == CMD_PAGE_ADDR) begin
                        state_d = StPgStart;
                    end else if (byte_data == CMD_DISP_OFF) begin
                        display_on_d = 1'b0;
                    end else if (byte_data == CMD_DISP_ON) begin
                        display_on_d = 1'b1;
                    end
                end
                StColStart: begin
                    col_start_d = byte_data[ColW-1:0];
                    col_d       = byte_data[ColW-1:0];
                    state_d     = StColEnd;
                end
                StColEnd: begin
                    col_end_d = byte_data[ColW-1:0];
                    state_d   = StIdle;
                end
                StPgStart: begin
                    page_start_d = byte_data[PageW-1:0];
                    page_d       = byte_data[PageW-1:0];
                    state_d      = StPgEnd;
                end
                StPgEnd: begin
                    page_end_d = byte_data[PageW-1:0];
                    state_d    = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state_q      <= StIdle;
            col_start_q  <= '0;
            col_end_q    <= '1;
            page_start_q <= '0;
            page_end_q   <= '1;
            col_q        <= '0;
            page_q       <= '0;
            display_on_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'h00;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= 8'h00;
            frame_done_q <= 1'b0;
            byte_count_q <= '0;
            frame_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            col_q        <= col_d;
            page_q       <= page_d;
            display_on_q <= display_on_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            frame_done_q <= frame_done_d;
            byte_count_q <= byte_count_d;
            frame_pend_q <= frame_pend_d;
        end
    end

endmodule

// File: tb/tb_receptor_display.sv
// Directed bench for receptor_display: drives the SPI link bit by bit and checks the
// write/command strobes against hand-computed expectations.
module tb_receptor_display;

    logic       clk = 1'b0;
    logic       rst, io_sclk, io_sdin, io_cs, io_dc, io_reset;
    logic       wr_en, cmd_valid, display_on, frame_done;
    logic [9:0] wr_addr, byte_count;
    logic [7:0] wr_data, cmd_byte;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    receptor_display dut (
        .clk       (clk),
        .rst       (rst),
        .io_sclk   (io_sclk),
        .io_sdin   (io_sdin),
        .io_cs     (io_cs),
        .io_dc     (io_dc),
        .io_reset  (io_reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .display_on(display_on),
        .frame_done(frame_done),
        .byte_count(byte_count)
    );

    typedef struct {
        logic       is_wr;
        logic [9:0] addr;
        logic [7:0] data;
        logic       fd;
        logic [9:0] cnt;
        logic [7:0] cb;
        logic       on;
    } ev_t;

    ev_t evq[$];

    always @(negedge clk) begin
        if (wr_en || cmd_valid) begin
            evq.push_back('{wr_en, wr_addr, wr_data, frame_done, byte_count, cmd_byte, display_on});
        end
    end

    typedef struct {
        logic [7:0] b;
        logic       dc;
        logic [9:0] addr;
        logic       fd;
        logic [9:0] cnt;
        logic       on;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
        for (int i = 0; i < n; i++) begin
            io_sdin = b[7-i];
            io_dc   = dc;
            cycles(2);
            io_sclk = 1'b1;
            cycles(2);
            io_sclk = 1'b0;
        end
    endtask

    task automatic wait_events(input int n, input string name);
        int t = 0;
        while (evq.size() < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_count"}, 32'(evq.size()), 32'(n));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t e;
        int  bad, first_bad, fd_seen;

        rst = 1'b1; io_sclk = 1'b0; io_sdin = 1'b0; io_cs = 1'b1; io_dc = 1'b0;
        io_reset = 1'b1;
        cycles(4);
        rst = 1'b0;
        cycles(4);

        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_cmd_byte", 32'(cmd_byte), 32'd0);
        chk("rst_byte_count", 32'(byte_count), 32'd0);
        chk("rst_display_on", 32'(display_on), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        // Single data byte after reset
        io_cs = 1'b0;
        cycles(4);
        send_bits(8'hA5, 8, 1'b1);
        wait_events(1, "single");
        if (evq.size() > 0) begin
            e = evq.pop_front();
            chk("single_is_wr", 32'(e.is_wr), 32'd1);
            chk("single_addr", 32'(e.addr), 32'd0);
            chk("single_data", 32'(e.data), 32'hA5);
            chk("single_cnt", 32'(e.cnt), 32'd1);
        end

        // Command decode and windowed addressing
        vt[0]  = '{8'hAF, 1'b0, 10'd0,   1'b0, 10'd0, 1'b1};
        vt[1]  = '{8'hAE, 1'b0, 10'd0,   1'b0, 10'd0, 1'b0};
        vt[2]  = '{8'h21, 1'b0, 10'd0,   1'b0, 10'd0, 1'b0};
        vt[3]  = '{8'h10, 1'b0, 10'd0,   1'b0, 10'd0, 1'b0};
        vt[4]  = '{8'h11, 1'b0, 10'd0,   1'b0, 10'd0, 1'b0};
        vt[5]  = '{8'h22, 1'b0, 10'd0,   1'b0, 10'd0, 1'b0};
        vt[6]  = '{8'h02, 1'b0, 10'd0,   1'b0, 10'd0, 1'b0};
        vt[7]  = '{8'h03, 1'b0, 10'd0,   1'b0, 10'd0, 1'b0};
        vt[8]  = '{8'h11, 1'b1, 10'd272, 1'b0, 10'd2, 1'b0};
        vt[9]  = '{8'h22, 1'b1, 10'd273, 1'b0, 10'd3, 1'b0};
        vt[10] = '{8'h33, 1'b1, 10'd400, 1'b0, 10'd4, 1'b0};
        vt[11] = '{8'h44, 1'b1, 10'd401, 1'b1, 10'd5, 1'b0};
        vt[12] = '{8'h55, 1'b1, 10'd272, 1'b0, 10'd1, 1'b0};

        for (int i = 0; i < 13; i++) begin
            send_bits(vt[i].b, 8, vt[i].dc);
            wait_events(1, $sformatf("vec%0d", i));
            if (evq.size() > 0) begin
                e = evq.pop_front();
                chk($sformatf("vec%0d_is_wr", i), 32'(e.is_wr), 32'(vt[i].dc));
                if (vt[i].dc) begin
                    chk($sformatf("vec%0d_addr", i), 32'(e.addr), 32'(vt[i].addr));
                    chk($sformatf("vec%0d_data", i), 32'(e.data), 32'(vt[i].b));
                    chk($sformatf("vec%0d_fd", i), 32'(e.fd), 32'(vt[i].fd));
                    chk($sformatf("vec%0d_cnt", i), 32'(e.cnt), 32'(vt[i].cnt));
                end else begin
                    chk($sformatf("vec%0d_cmd_byte", i), 32'(e.cb), 32'(vt[i].b));
                    chk($sformatf("vec%0d_display_on", i), 32'(e.on), 32'(vt[i].on));
                end
            end
        end

        // Restore default window, then a full frame plus one byte, streamed back to back
        send_bits(8'h21, 8, 1'b0); send_bits(8'h00, 8, 1'b0); send_bits(8'h7F, 8, 1'b0);
        send_bits(8'h22, 8, 1'b0); send_bits(8'h00, 8, 1'b0); send_bits(8'h07, 8, 1'b0);
        wait_events(6, "window_restore");
        evq.delete();
        for (int i = 0; i < 1025; i++) begin
            send_bits(8'(i) ^ 8'h5A, 8, 1'b1);
        end
        wait_events(1025, "frame");
        bad = 0; first_bad = -1; fd_seen = 0;
        for (int i = 0; i < 1025 && evq.size() > 0; i++) begin
            e = evq.pop_front();
            if (e.fd) fd_seen++;
            if (!e.is_wr || e.addr != 10'(i % 1024) || e.data != (8'(i) ^ 8'h5A) ||
                e.fd != (i == 1023)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            if (i == 1024) chk("frame_next_cnt", 32'(e.cnt), 32'd1);
        end
        chk("frame_seq_bad", 32'(bad), 32'd0);
        if (bad != 0) $display("  first bad frame index %0d", first_bad);
        chk("frame_done_pulses", 32'(fd_seen), 32'd1);

        // Aborted partial byte followed by a complete one
        evq.delete();
        send_bits(8'hF8, 5, 1'b1);
        cycles(2);
        io_cs = 1'b1;
        cycles(6);
        io_cs = 1'b0;
        cycles(4);
        send_bits(8'h3C, 8, 1'b1);
        cycles(20);
        chk("abort_count", 32'(evq.size()), 32'd1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            chk("abort_data", 32'(e.data), 32'h3C);
        end
        evq.delete();

        // Display reset in the middle of a windowed stream
        send_bits(8'hAF, 8, 1'b0);
        send_bits(8'h21, 8, 1'b0); send_bits(8'h05, 8, 1'b0); send_bits(8'h09, 8, 1'b0);
        for (int i = 0; i < 600; i++) begin
            send_bits(8'(i), 8, 1'b1);
        end
        wait_events(604, "pre_reset");
        evq.delete();
        chk("pre_reset_on", 32'(display_on), 32'd1);
        io_reset = 1'b0;
        cycles(3);
        io_reset = 1'b1;
        cycles(8);
        chk("dreset_display_on", 32'(display_on), 32'd0);
        chk("dreset_byte_count", 32'(byte_count), 32'd0);
        chk("dreset_wr_addr", 32'(wr_addr), 32'd0);
        for (int i = 0; i < 11; i++) begin
            send_bits(8'hC0 + 8'(i), 8, 1'b1);
        end
        wait_events(11, "post_reset");
        bad = 0;
        for (int i = 0; i < 11 && evq.size() > 0; i++) begin
            e = evq.pop_front();
            if (i == 0) chk("post_reset_cnt", 32'(e.cnt), 32'd1);
            if (e.addr != 10'(i)) bad++;
        end
        chk("post_reset_addr_bad", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
